// File: rtl/int_ctrl_if.sv
// int_ctrl_if: request/acknowledge bus between the interrupt controller and the control unit
interface int_ctrl_if #(parameter int NIRQ = 4);
  logic [NIRQ-1:0] irq;
  logic            mask_we;
  logic [NIRQ-1:0] mask_wd;
  logic            ien_set;
  logic            ien_clr;
  logic            int_ack;
  logic            reti;
  logic            int_req;
  logic [9:0]      int_vec;
  logic            in_service;
  logic [NIRQ-1:0] pending;
  modport master (
    output irq, mask_we, mask_wd, ien_set, ien_clr, int_ack, reti,
    input  int_req, int_vec, in_service, pending
  );
  modport slave (
    input  irq, mask_we, mask_wd, ien_set, ien_clr, int_ack, reti,
    output int_req, int_vec, in_service, pending
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: prioritised vectored interrupt controller; define INT_EDGE_EN for edge-latched pending flags (level-following otherwise)
module int_ctrl #(
  parameter int         NIRQ     = 4,
  parameter logic [9:0] VEC_BASE = 10'h3F0
) (
  input logic       clk,
  input logic       reset,
  int_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t          state, state_nxt;
  logic [1:0]      id, id_nxt, pick;
  logic [NIRQ-1:0] s1, s2, pend, pend_nxt, mask, active;
  logic            ien, ien_nxt, ack;
`ifdef INT_EDGE_EN
  logic [NIRQ-1:0] s3;
`endif
  assign active = pend & mask;
  assign ack    = state == REQ && bus.int_ack;
  // lowest-index enabled pending line wins arbitration
  always_comb begin
    pick = '0;
    for (int i = NIRQ - 1; i >= 0; i--) if (active[i]) pick = 2'(i);
  end
  // next state, latched line id and global enable; disable beats every set source
  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    ien_nxt   = !bus.ien_clr && !ack && (bus.ien_set || ien || (state == SERVICE && bus.reti));
    if (state == IDLE && ien && |active) begin
      state_nxt = REQ;
      id_nxt    = pick;
    end
    if (ack) state_nxt = SERVICE;
    else if (state == REQ && bus.ien_clr) state_nxt = IDLE;
    if (state == SERVICE && bus.reti) state_nxt = IDLE;
  end
  // pending flags: a fresh edge outranks the acknowledge clear in the same cycle
  always_comb begin
`ifdef INT_EDGE_EN
    pend_nxt = (pend & ~(ack ? NIRQ'(1) << id : '0)) | (s2 & ~s3);
`else
    pend_nxt = s2;
`endif
  end
  // all state, including the irq synchronizers, clears asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      id    <= '0;
      s1    <= '0;
      s2    <= '0;
      pend  <= '0;
      mask  <= '0;
      ien   <= 1'b0;
`ifdef INT_EDGE_EN
      s3    <= '0;
`endif
    end else begin
      state <= state_nxt;
      id    <= id_nxt;
      s1    <= bus.irq;
      s2    <= s1;
      pend  <= pend_nxt;
      mask  <= bus.mask_we ? bus.mask_wd : mask;
      ien   <= ien_nxt;
`ifdef INT_EDGE_EN
      s3    <= s2;
`endif
    end
  end
  assign bus.int_req    = state == REQ;
  assign bus.in_service = state == SERVICE;
  assign bus.int_vec    = state == REQ ? VEC_BASE + {6'b0, id, 2'b00} : VEC_BASE;
  assign bus.pending    = pend;
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NIRQ, default 4, number of interrupt lines; legal range 1..4.
REQ-002 Parameter VEC_BASE, default 10'h3F0, first vector address; line i vector = VEC_BASE + 4*i, modulo 2^10.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 irq  input  NIRQ  external requests, asynchronous to clk.
REQ-006 mask_we  input  1  writes mask_wd into the mask register.
REQ-007 mask_wd  input  NIRQ  mask value; 1 = line enabled.
REQ-008 ien_set  input  1  global enable set (EI instruction).
REQ-009 ien_clr  input  1  global enable clear (DI instruction).
REQ-010 int_ack  input  1  control unit accepted the request: return PC pushed to stack, PC loaded from int_vec.
REQ-011 reti  input  1  return-from-interrupt executed.
REQ-012 int_req  output  1  interrupt request to the control unit.
REQ-013 int_vec  output  10  vector address for the PC mux.
REQ-014 in_service  output  1  high while a handler is running.
REQ-015 pending  output  NIRQ  pending flags, pre-mask.

Function
REQ-016 Each irq bit SHALL pass a 2-flop synchronizer before any other use.
REQ-017 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-018 IDLE: if ien=1 and (pending & mask) != 0, latch lowest-index active line as id and go to REQ next edge.
REQ-019 REQ: int_req=1; int_vec = VEC_BASE + 4*id, held stable until leaving REQ; id not re-arbitrated in REQ.
REQ-020 REQ + int_ack: go to SERVICE, clear ien, clear pending[id] (edge mode).
REQ-021 REQ + ien_clr without int_ack: return to IDLE, int_req drops next edge, pending kept; int_ack and ien_clr together: int_ack wins.
REQ-022 SERVICE: in_service=1, int_req=0; reti returns to IDLE and sets ien=1.
REQ-023 reti in IDLE or REQ SHALL be ignored; int_ack outside REQ SHALL be ignored.
REQ-024 ien_set and ien_clr together: clear wins.
REQ-025 New edge on line id in the same cycle its pending bit is cleared: set wins.
REQ-026 mask_we takes effect next edge; masking a line does not clear its pending bit.
REQ-027 Latency: irq change sampled at edge k -> pending at edge k+2 -> int_req at edge k+3.
REQ-028 int_vec SHALL equal VEC_BASE when not in REQ.

Reset
REQ-029 reset SHALL asynchronously force: state IDLE, int_req=0, in_service=0, int_vec=VEC_BASE, pending=0, mask=0, ien=0, synchronizers=0.
REQ-030 reset during REQ or SERVICE SHALL abandon the interrupt without any further int_req.

Configuration
REQ-031 Macro INT_EDGE_EN defined: pending[i] set by a synchronized 0->1 edge, held until cleared by int_ack for that line.
REQ-032 INT_EDGE_EN undefined: pending[i] equals the synchronized irq level each cycle; int_ack does not clear it; the source deasserts in the handler.

Verification
REQ-033 Edge mode, mask=4'b1111, ien=1, irq[2] rises -> int_req high 3 edges later, int_vec=10'h3F8; int_ack -> in_service=1, pending[2]=0, ien=0.
REQ-034 irq[1] and irq[3] rise together -> int_vec=10'h3F4; after reti, second request with int_vec=10'h3FC.
REQ-035 ien=0, irq[0] pending -> no int_req; ien_set -> int_req next edge with int_vec=10'h3F0.
REQ-036 In REQ, ien_clr pulse without int_ack -> int_req low next edge, pending unchanged; ien_set -> same request reissued.
REQ-037 reset asserted mid-SERVICE -> all outputs at reset values immediately, no request after release until a new edge.
REQ-038 Level mode: irq[0] held high through reti -> handler re-entered; irq[0] low before reti -> returns to IDLE, int_req stays 0.
